// File: rtl/candy_mem.sv
// candy_mem: memory-access stage; ALU/store pass-through, loads issued to SRAM with a read timeout.
module candy_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [1:0]            ex_op,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [ADDR_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_reg_addr,
    output logic                  sram_re,
    output logic [ADDR_W-1:0]     sram_raddr,
    input  logic                  sram_rvalid,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  wb_enable,
    output logic                  is_mem,
    output logic [DATA_W-1:0]     result,
    output logic [ADDR_W-1:0]     sram_result_addr,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic                  mem_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    typedef enum logic {IDLE, READ_WAIT} state_t;
    state_t r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [REG_ADDR_W-1:0] r_lreg;
    logic w_accept, w_rvalid, w_timeout;
    assign ex_ready  = (r_state == IDLE);
    assign w_accept  = ex_valid & ex_ready;
    // the strobe cycle never carries read data, so rvalid is masked while sram_re is high
    assign w_rvalid  = sram_rvalid & ~sram_re;
    assign w_timeout = (r_cnt == CNT_MAX);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = (w_accept && ex_op == 2'b01) ? READ_WAIT : IDLE;
        else                 w_next = (w_rvalid || w_timeout) ? IDLE : READ_WAIT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable        <= 1'b0;
            is_mem           <= 1'b0;
            result           <= '0;
            sram_result_addr <= '0;
            reg_addr         <= '0;
            sram_re          <= 1'b0;
            sram_raddr       <= '0;
            mem_err          <= 1'b0;
            r_cnt            <= '0;
            r_lreg           <= '0;
        end else begin
            wb_enable <= 1'b0;
            sram_re   <= 1'b0;
            mem_err   <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    case (ex_op)
                        2'b00: begin
                            wb_enable <= 1'b1;
                            is_mem    <= 1'b0;
                            result    <= ex_alu_result;
                            reg_addr  <= ex_reg_addr;
                        end
                        2'b10: begin
                            wb_enable        <= 1'b1;
                            is_mem           <= 1'b1;
                            result           <= ex_store_data;
                            sram_result_addr <= ex_mem_addr;
                        end
                        2'b01: begin
                            sram_re    <= 1'b1;
                            sram_raddr <= ex_mem_addr;
                            r_lreg     <= ex_reg_addr;
                            r_cnt      <= '0;
                        end
                        default: ;
                    endcase
                end
            end else if (w_rvalid) begin
                wb_enable <= 1'b1;
                is_mem    <= 1'b0;
                result    <= sram_rdata;
                reg_addr  <= r_lreg;
            end else if (w_timeout) begin
                mem_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_candy_mem.sv
// tb_candy_mem: directed and random checks of candy_mem against a cycle-level reference model.
module tb_candy_mem;
    localparam int DW = 32, AW = 16, RW = 5, TO = 15;
    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 1'b0, ex_ready, sram_re, sram_rvalid = 1'b0;
    logic [1:0] ex_op = '0;
    logic [DW-1:0] ex_alu_result = '0, ex_store_data = '0, sram_rdata = '0, result;
    logic [AW-1:0] ex_mem_addr = '0, sram_raddr, sram_result_addr;
    logic [RW-1:0] ex_reg_addr = '0, reg_addr;
    logic wb_enable, is_mem, mem_err;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    candy_mem #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_alu_result(ex_alu_result), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .ex_reg_addr(ex_reg_addr), .sram_re(sram_re), .sram_raddr(sram_raddr),
        .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata), .wb_enable(wb_enable), .is_mem(is_mem),
        .result(result), .sram_result_addr(sram_result_addr), .reg_addr(reg_addr), .mem_err(mem_err)
    );
    // reference: a load is outstanding for a number of cycles; data counts once the strobe cycle is past
    bit m_busy = 0;
    int m_age = 0;
    logic [RW-1:0] m_reg = '0;
    logic e_wb = 0, e_mem = 0, e_re = 0, e_err = 0;
    logic [DW-1:0] e_res = '0;
    logic [AW-1:0] e_sa = '0, e_raddr = '0;
    logic [RW-1:0] e_ra = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_age = 0; m_reg = '0;
            e_wb = 0; e_mem = 0; e_re = 0; e_err = 0; e_res = '0; e_sa = '0; e_raddr = '0; e_ra = '0;
        end else begin
            e_wb = 0; e_re = 0; e_err = 0;
            if (!m_busy) begin
                if (ex_valid && ex_op == 2'd0) begin e_wb = 1; e_mem = 0; e_res = ex_alu_result; e_ra = ex_reg_addr; end
                if (ex_valid && ex_op == 2'd2) begin e_wb = 1; e_mem = 1; e_res = ex_store_data; e_sa = ex_mem_addr; end
                if (ex_valid && ex_op == 2'd1) begin e_re = 1; e_raddr = ex_mem_addr; m_reg = ex_reg_addr; m_busy = 1; m_age = 0; end
            end else if (m_age > 0 && sram_rvalid) begin
                e_wb = 1; e_mem = 0; e_res = sram_rdata; e_ra = m_reg; m_busy = 0;
            end else if (m_age == TO) begin
                e_err = 1; m_busy = 0;
            end else m_age++;
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check_all();
        chk("ex_ready", ex_ready, !m_busy);
        chk("wb_enable", wb_enable, e_wb);
        chk("is_mem", is_mem, e_mem);
        chk("result", result, e_res);
        chk("sram_result_addr", sram_result_addr, e_sa);
        chk("reg_addr", reg_addr, e_ra);
        chk("sram_re", sram_re, e_re);
        chk("sram_raddr", sram_raddr, e_raddr);
        chk("mem_err", mem_err, e_err);
    endtask
    task automatic cyc(input logic v, input logic [1:0] op, input logic [DW-1:0] alu, input logic [AW-1:0] a,
                       input logic [DW-1:0] sd, input logic [RW-1:0] r, input logic rv, input logic [DW-1:0] rd);
        @(negedge clk);
        ex_valid = v; ex_op = op; ex_alu_result = alu; ex_mem_addr = a;
        ex_store_data = sd; ex_reg_addr = r; sram_rvalid = rv; sram_rdata = rd;
        @(posedge clk); #1;
        check_all();
    endtask
    task automatic idle();
        cyc(0, 2'd0, '0, '0, '0, '0, 0, '0);
    endtask
    initial begin
        #3;
        check_all();
        chk("init_ready", ex_ready, 1);
        @(negedge clk); rst = 0;
        cyc(1, 2'd0, 32'h1234, '0, '0, 5'd5, 0, '0);
        chk("alu_wb", wb_enable, 1); chk("alu_res", result, 32'h1234); chk("alu_reg", reg_addr, 5);
        cyc(1, 2'd2, '0, 16'h0040, 32'hDEADBEEF, 5'd9, 0, '0);
        chk("st_wb", wb_enable, 1); chk("st_mem", is_mem, 1); chk("st_res", result, 32'hDEADBEEF);
        chk("st_addr", sram_result_addr, 16'h0040); chk("st_reg_hold", reg_addr, 5);
        @(negedge clk); #2 rst = 1; #1;
        check_all();
        chk("rst_res", result, 0); chk("rst_addr", sram_result_addr, 0); chk("rst_ready", ex_ready, 1);
        @(negedge clk); rst = 0;
        cyc(1, 2'd1, '0, 16'h0100, '0, 5'd7, 0, '0);
        chk("ld_re", sram_re, 1); chk("ld_raddr", sram_raddr, 16'h0100); chk("ld_ready", ex_ready, 0);
        cyc(1, 2'd0, 32'hBAD, '0, '0, 5'd1, 0, '0);
        chk("ld_re_pulse", sram_re, 0); chk("ld_no_wb", wb_enable, 0);
        idle();
        cyc(0, 2'd0, '0, '0, '0, '0, 1, 32'hCAFEF00D);
        chk("ld_wb", wb_enable, 1); chk("ld_res", result, 32'hCAFEF00D); chk("ld_reg", reg_addr, 7);
        chk("ld_ismem", is_mem, 0); chk("ld_ready_back", ex_ready, 1);
        cyc(1, 2'd0, 32'h77, '0, '0, 5'd2, 0, '0);
        chk("after_ld_alu", wb_enable, 1);
        cyc(1, 2'd1, '0, 16'h0300, '0, 5'd4, 0, '0);
        for (int k = 1; k <= TO; k++) begin
            idle();
            chk("to_early", mem_err, 0);
        end
        idle();
        chk("to_err", mem_err, 1); chk("to_no_wb", wb_enable, 0);
        idle();
        chk("to_err_pulse", mem_err, 0); chk("to_ready", ex_ready, 1);
        cyc(0, 2'd0, '0, '0, '0, '0, 1, 32'h1111);
        chk("stray_no_wb", wb_enable, 0);
        cyc(1, 2'd1, '0, 16'h0310, '0, 5'd6, 0, '0);
        for (int k = 1; k <= TO; k++) idle();
        cyc(0, 2'd0, '0, '0, '0, '0, 1, 32'h2222);
        chk("edge_wb", wb_enable, 1); chk("edge_no_err", mem_err, 0); chk("edge_reg", reg_addr, 6);
        cyc(1, 2'd1, '0, 16'h0200, '0, 5'd9, 0, '0);
        idle();
        @(negedge clk); #2 rst = 1; #1;
        check_all();
        chk("rw_rst_ready", ex_ready, 1);
        @(negedge clk); rst = 0;
        cyc(0, 2'd0, '0, '0, '0, '0, 1, 32'h3333);
        chk("post_rst_no_wb", wb_enable, 0);
        cyc(1, 2'd0, 32'h55, '0, '0, 5'd3, 0, '0);
        chk("post_rst_alu", result, 32'h55);
        cyc(1, 2'd0, 32'hA1, '0, '0, 5'd10, 0, '0);
        chk("nop_a", wb_enable, 1);
        cyc(1, 2'd3, 32'hFF, 16'hFFFF, 32'hFF, 5'd11, 0, '0);
        chk("nop_gap", wb_enable, 0); chk("nop_no_re", sram_re, 0);
        cyc(1, 2'd0, 32'hA2, '0, '0, 5'd12, 0, '0);
        chk("nop_b", wb_enable, 1); chk("nop_b_res", result, 32'hA2);
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), 2'($urandom), $urandom, 16'($urandom), $urandom, 5'($urandom),
                1'($urandom_range(0, 99) < ((i % 1000) < 500 ? 30 : 2)), $urandom);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/candy_mem.md
Name: candy_mem

Overview:
Memory-access stage between the execute stage and the writeback stage.
- Accepts one instruction per handshake from execute.
- ALU results and stores pass straight through to writeback.
- Loads are issued to the SRAM read port; the stage waits, with a timeout, for read data.
- Produces the single-cycle writeback bundle: wb_enable, is_mem, result, sram_result_addr, reg_addr.

Parameters:
DATA_W, 32, width of ALU results, SRAM data and register data
ADDR_W, 16, SRAM address width
REG_ADDR_W, 5, register-file address width
TIMEOUT, 15, maximum READ_WAIT cycles without sram_rvalid before a load is aborted (>=1)

Ports:
clk  in  1  stage clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  execute presents an instruction
ex_ready  out  1  stage can accept; combinational, equals (state==IDLE)
ex_op  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved/NOP
ex_alu_result  in  DATA_W  ALU result
ex_mem_addr  in  ADDR_W  load/store address
ex_store_data  in  DATA_W  store data
ex_reg_addr  in  REG_ADDR_W  destination register
sram_re  out  1  SRAM read strobe, one-cycle pulse
sram_raddr  out  ADDR_W  SRAM read address
sram_rvalid  in  1  read data valid
sram_rdata  in  DATA_W  read data
wb_enable  out  1  writeback strobe, one-cycle pulse per instruction
is_mem  out  1  1 = SRAM write, 0 = register write
result  out  DATA_W  data to write back
sram_result_addr  out  ADDR_W  SRAM write address (store only)
reg_addr  out  REG_ADDR_W  destination register (ALU/load)
mem_err  out  1  one-cycle pulse on load timeout

Behaviour:
- States: IDLE, READ_WAIT. Accept = ex_valid & ex_ready.
- Reset (async, any state): state=IDLE, wait counter=0, all outputs 0 (wb_enable, is_mem, result, sram_result_addr, reg_addr, sram_re, sram_raddr, mem_err). An in-flight load is discarded. An sram_rvalid arriving after reset deasserts is ignored.
- All outputs except ex_ready are registered. wb_enable, sram_re and mem_err default to 0 every cycle unless set below.
- IDLE, accept ALU: next cycle wb_enable=1, is_mem=0, result=ex_alu_result, reg_addr=ex_reg_addr. Latency 1. Stay in IDLE.
- IDLE, accept STORE: next cycle wb_enable=1, is_mem=1, result=ex_store_data, sram_result_addr=ex_mem_addr. Latency 1. Stay in IDLE.
- IDLE, accept op 11: consumed. No wb_enable, no sram_re. Stay in IDLE.
- IDLE, accept LOAD:
  - Next cycle sram_re=1 and sram_raddr=ex_mem_addr.
  - ex_reg_addr is latched internally; counter=0; go to READ_WAIT.
- Back-to-back ALU/STORE accepts give wb_enable high on consecutive cycles with no bubble.
- Fields not written by an instruction hold their previous values (e.g. reg_addr holds during a STORE).
- READ_WAIT (ex_ready=0):
  - sram_rvalid is sampled only while sram_re==0. The SRAM never returns data in the same cycle as the strobe.
  - rvalid=1: next cycle wb_enable=1, is_mem=0, result=sram_rdata, reg_addr=latched register; go to IDLE.
  - rvalid=0 and counter==TIMEOUT: next cycle mem_err=1, no wb_enable; go to IDLE.
  - Otherwise counter+1.
  - rvalid and timeout in the same cycle: rvalid wins, no mem_err.
- Minimum load latency (accept edge to wb_enable): 3 cycles.
- sram_rvalid in IDLE is ignored (stray response).
- The counter is wide enough to hold TIMEOUT, i.e. clog2(TIMEOUT+1) bits, and never wraps.
- ex_* inputs are sampled only at accept. Changes while ex_ready=0 have no effect.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately, ex_ready=1.
- ALU then STORE back-to-back: op00 result=0x1234 reg=5, then op10 addr=0x0040 data=0xDEADBEEF -> wb_enable high 2 consecutive cycles. First cycle: is_mem=0, result=0x1234, reg_addr=5. Second cycle: is_mem=1, result=0xDEADBEEF, sram_result_addr=0x0040.
- LOAD, 2-cycle SRAM: op01 addr=0x0100 reg=7, rvalid with rdata=0xCAFEF00D two cycles after sram_re -> sram_re one pulse with raddr=0x0100, ex_ready low until return, then wb_enable with is_mem=0, result=0xCAFEF00D, reg_addr=7; new ALU accepted the next cycle.
- LOAD timeout: TIMEOUT=15, rvalid never asserted -> exactly one mem_err pulse, no wb_enable, IDLE restored; a later stray rvalid produces no writeback.
- Reset during READ_WAIT, then rvalid after reset -> no wb_enable, state IDLE; a subsequent ALU op writes back normally.
- Reserved op 11 between two ALU ops -> exactly two wb_enable pulses, with a gap cycle between them.
